muldiv_unit: RTL

- Multi-cycle RV64M multiply/divide unit in the execute stage.
- Takes operands from the E pipeline register and produces the result that is written into the M register.
- Drives mult_ok, which the hazard unit uses to stall F/D/E and flush M while an operation is in flight.
- Holds its finished result until the execute stage actually advances.

---
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit for the execute stage.
// Multiplies finish after MUL_CYCLES cycles; divides run restoring radix-2, one quotient bit per cycle.
module muldiv_unit #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hold,
    input  logic            flush,
    output logic            mult_ok,
    output logic [XLEN-1:0] result
);
    localparam int unsigned HW   = XLEN / 2;
    localparam int unsigned CMAX = (MUL_CYCLES > XLEN) ? MUL_CYCLES : XLEN;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            word_q, word_d;
    logic [XLEN:0]   ma, ma_d, mb, mb_d;
    logic [XLEN-1:0] quo, quo_d, rem, rem_d, dvs, dvs_d;
    logic            q_neg, q_neg_d, r_neg, r_neg_d;
    logic [XLEN-1:0] res_q, res_d;

    function automatic logic [XLEN-1:0] wfit(input logic [XLEN-1:0] v, input logic w);
        return w ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
    endfunction

    // Operand conditioning straight from the E register inputs
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf;
    logic [XLEN-1:0] ax, bx, a_mag, b_mag;

    always_comb begin
        is_div = op[2];
        a_sgn  = is_div ? ~op[0] : (op[1:0] != 2'b11);
        b_sgn  = is_div ? ~op[0] : ~op[1];
        ax     = word ? {{HW{a_sgn & a[HW-1]}}, a[HW-1:0]} : a;
        bx     = word ? {{HW{b_sgn & b[HW-1]}}, b[HW-1:0]} : b;
        a_neg  = a_sgn & ax[XLEN-1];
        b_neg  = b_sgn & bx[XLEN-1];
        a_mag  = a_neg ? -ax : ax;
        b_mag  = b_neg ? -bx : bx;
        b_zero = (bx == '0);
        ovf    = a_sgn & (bx == '1) &
                 (word ? (a[HW-1:0] == {1'b1, {(HW-1){1'b0}}})
                       : (a == {1'b1, {(XLEN-1){1'b0}}}));
    end

    // The multiplier sees live operands in IDLE so MUL_CYCLES=1 can finish on the start edge
    logic [XLEN:0]       mul_a, mul_b;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     mul_lo, mul_hi;

    always_comb begin
        mul_a  = (state == IDLE) ? {a_neg, ax} : ma;
        mul_b  = (state == IDLE) ? {b_neg, bx} : mb;
        prod   = $signed({{(XLEN-1){mul_a[XLEN]}}, mul_a}) *
                 $signed({{(XLEN-1){mul_b[XLEN]}}, mul_b});
        mul_lo = prod[XLEN-1:0];
        mul_hi = prod[2*XLEN-1:XLEN];
    end

    // One restoring step: the quotient register also carries the unconsumed dividend bits
    logic [XLEN:0]   part;
    logic            ge;
    logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix;

    always_comb begin
        part     = {rem, quo[XLEN-1]};
        ge       = (part >= {1'b0, dvs});
        rem_step = ge ? XLEN'(part - {1'b0, dvs}) : part[XLEN-1:0];
        quo_step = {quo[XLEN-2:0], ge};
        q_fix    = q_neg ? -quo_step : quo_step;
        r_fix    = r_neg ? -rem_step : rem_step;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_d    = op_q;
        word_d  = word_q;
        ma_d    = ma;
        mb_d    = mb;
        quo_d   = quo;
        rem_d   = rem;
        dvs_d   = dvs;
        q_neg_d = q_neg;
        r_neg_d = r_neg;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        op_d   = op[1:0];
                        word_d = word;
                        if (!is_div) begin
                            ma_d = {a_neg, ax};
                            mb_d = {b_neg, bx};
                            if (MUL_CYCLES <= 1) begin
                                state_d = DONE;
                                res_d   = wfit((op[1:0] == 2'b00) ? mul_lo : mul_hi, word);
                            end else begin
                                state_d = MUL;
                                cnt_d   = CW'(MUL_CYCLES - 1);
                            end
                        end else if (b_zero) begin
                            state_d = DONE;
                            quo_d   = '1;
                            rem_d   = ax;
                            res_d   = wfit(op[1] ? ax : '1, word);
                        end else if (ovf) begin
                            state_d = DONE;
                            quo_d   = ax;
                            rem_d   = '0;
                            res_d   = wfit(op[1] ? '0 : ax, word);
                        end else begin
                            state_d = DIV;
                            cnt_d   = word ? CW'(HW - 1) : CW'(XLEN - 1);
                            quo_d   = word ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
                            rem_d   = '0;
                            dvs_d   = b_mag;
                            q_neg_d = a_neg ^ b_neg;
                            r_neg_d = a_neg;
                        end
                    end
                end
                MUL: begin
                    cnt_d = cnt - CW'(1);
                    if (cnt_d == '0) begin
                        state_d = DONE;
                        res_d   = wfit((op_q == 2'b00) ? mul_lo : mul_hi, word_q);
                    end
                end
                DIV: begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt - CW'(1);
                    if (cnt == '0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        quo_d   = q_fix;
                        rem_d   = r_fix;
                        res_d   = wfit(op_q[1] ? r_fix : q_fix, word_q);
                    end
                end
                DONE: begin
                    if (!hold) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            word_q <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            res_q  <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            op_q   <= op_d;
            word_q <= word_d;
            ma     <= ma_d;
            mb     <= mb_d;
            quo    <= quo_d;
            rem    <= rem_d;
            dvs    <= dvs_d;
            q_neg  <= q_neg_d;
            r_neg  <= r_neg_d;
            res_q  <= res_d;
        end
    end

    assign mult_ok = ((state == IDLE) && !valid) || (state == DONE);
    assign result  = res_q;

endmodule
